alu_secuenciador: RTL and testbench

Command sequencer that sits in front of the generalized ALU and is its upstream driver. It accepts a stream of words over a valid/ready handshake: operand A, then operand B, then opcode. It drives the ALU operand/opcode inputs from internal registers, captures the combinational ALU result, and presents it on a valid/ready output port. The parent module instantiates the ALU next to this block and connects the two.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 29 ++
 rtl/alu_secuenciador.sv | 121 ++++++++++++
 tb/tb_alu_secuenciador.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
//   - Opcode encodings understood by the ALU.
//   - Sequencer FSM state encoding.
//   - Helper that flags opcodes outside the supported set.
package alu_pkg;

  localparam logic [2:0] OP_SUMA  = 3'b001;
  localparam logic [2:0] OP_RESTA = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;

  typedef enum logic [2:0] {
    CARGA_A,
    CARGA_B,
    CARGA_OP,
    EJECUTA,
    ENTREGA
  } estado_t;

  function automatic logic op_invalido(input logic [2:0] op);
    return !((op == OP_SUMA) || (op == OP_RESTA) ||
             (op == OP_AND)  || (op == OP_OR));
  endfunction

endpackage

// File: rtl/alu.sv
// Generalized combinational ALU driven by alu_secuenciador.
// Ports:
//   a, b       in  N_BITS  operands
//   op         in  3       opcode (OP_SUMA/OP_RESTA/OP_AND/OP_OR)
//   resultado  out N_BITS  result; 0 for unsupported opcodes
// Addition and subtraction wrap modulo 2^N_BITS (carry/borrow dropped).
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [2:0]        op,
  output logic [N_BITS-1:0] resultado
);

  always_comb begin
    resultado = '0;
    case (op)
      OP_SUMA:  resultado = a + b;
      OP_RESTA: resultado = a - b;
      OP_AND:   resultado = a & b;
      OP_OR:    resultado = a | b;
      default:  resultado = '0;
    endcase
  end

endmodule

// File: rtl/alu_secuenciador.sv
// Command sequencer placed upstream of the ALU.
// Accepts operand A, operand B and opcode as three words on a valid/ready
// input port, drives the ALU from registers, captures the combinational ALU
// result and offers it on a valid/ready output port.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   dato_in/dato_valid/dato_ready       input word stream
//   cancelar                            abort a partially loaded command
//   alu_a/alu_b/alu_op                  registered ALU operands/opcode
//   alu_resultado                       combinational ALU result
//   resultado/resultado_valid/_ready    output result handshake
//   error_op                            captured opcode was unsupported
//   contador_ops                        delivered-result counter (mod 256)
module alu_secuenciador
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] dato_in,
  input  logic              dato_valid,
  output logic              dato_ready,
  input  logic              cancelar,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [N_BITS-1:0] alu_resultado,
  output logic [N_BITS-1:0] resultado,
  output logic              resultado_valid,
  input  logic              resultado_ready,
  output logic              error_op,
  output logic [7:0]        contador_ops
);

  estado_t estado, estado_sig;
  logic    carga_a, carga_b, carga_op, captura, entregado;

  // Only the opcode field of the third word is meaningful.
  logic unused_dato_alto;
  assign unused_dato_alto = ^dato_in[N_BITS-1:3];

  // Handshake outputs depend on state alone.
  assign dato_ready      = (estado == CARGA_A) || (estado == CARGA_B) ||
                           (estado == CARGA_OP);
  assign resultado_valid = (estado == ENTREGA);

  always_comb begin
    estado_sig = estado;
    carga_a    = 1'b0;
    carga_b    = 1'b0;
    carga_op   = 1'b0;
    captura    = 1'b0;
    entregado  = 1'b0;
    case (estado)
      CARGA_A: begin
        if (dato_valid) begin
          carga_a    = 1'b1;
          estado_sig = CARGA_B;
        end
      end
      CARGA_B: begin
        // cancelar wins over a simultaneous transfer
        if (cancelar) begin
          estado_sig = CARGA_A;
        end else if (dato_valid) begin
          carga_b    = 1'b1;
          estado_sig = CARGA_OP;
        end
      end
      CARGA_OP: begin
        if (cancelar) begin
          estado_sig = CARGA_A;
        end else if (dato_valid) begin
          carga_op   = 1'b1;
          estado_sig = EJECUTA;
        end
      end
      EJECUTA: begin
        captura    = 1'b1;
        estado_sig = ENTREGA;
      end
      ENTREGA: begin
        if (resultado_ready) begin
          entregado  = 1'b1;
          estado_sig = CARGA_A;
        end
      end
      default: estado_sig = CARGA_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= CARGA_A;
    end else begin
      estado <= estado_sig;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= 3'b000;
      resultado    <= '0;
      error_op     <= 1'b0;
      contador_ops <= 8'd0;
    end else begin
      if (carga_a)  alu_a  <= dato_in;
      if (carga_b)  alu_b  <= dato_in;
      if (carga_op) alu_op <= dato_in[2:0];
      if (captura) begin
        resultado <= alu_resultado;
        error_op  <= op_invalido(alu_op);
      end
      if (entregado) contador_ops <= contador_ops + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Directed bench for alu_secuenciador paired with the ALU (N_BITS = 8).
module tb_alu_secuenciador;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] dato_in;
  logic         dato_valid;
  logic         dato_ready;
  logic         cancelar;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_resultado;
  logic [N-1:0] resultado;
  logic         resultado_valid;
  logic         resultado_ready;
  logic         error_op;
  logic [7:0]   contador_ops;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_secuenciador #(.N_BITS(N)) dut (
    .clk(clk), .reset(reset),
    .dato_in(dato_in), .dato_valid(dato_valid), .dato_ready(dato_ready),
    .cancelar(cancelar),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_resultado(alu_resultado),
    .resultado(resultado), .resultado_valid(resultado_valid),
    .resultado_ready(resultado_ready),
    .error_op(error_op), .contador_ops(contador_ops)
  );

  alu #(.N_BITS(N)) u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .resultado(alu_resultado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] w);
    dato_in    = w;
    dato_valid = 1'b1;
    tick();
    dato_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " alu_a"}, 32'(alu_a), 0);
    chk({tag, " alu_b"}, 32'(alu_b), 0);
    chk({tag, " alu_op"}, 32'(alu_op), 0);
    chk({tag, " resultado"}, 32'(resultado), 0);
    chk({tag, " resultado_valid"}, 32'(resultado_valid), 0);
    chk({tag, " error_op"}, 32'(error_op), 0);
    chk({tag, " contador_ops"}, 32'(contador_ops), 0);
    chk({tag, " dato_ready"}, 32'(dato_ready), 1);
  endtask

  // Full command with resultado_ready held high; checks the valid window.
  task automatic run_cmd(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] op, input logic [N-1:0] exp_res,
                         input logic exp_err);
    resultado_ready = 1'b1;
    send(a);
    send(b);
    send(op);
    chk({tag, " valid after op edge"}, 32'(resultado_valid), 0);
    chk({tag, " ready in EJECUTA"}, 32'(dato_ready), 0);
    tick();
    chk({tag, " valid 2nd edge"}, 32'(resultado_valid), 1);
    chk({tag, " resultado"}, 32'(resultado), 32'(exp_res));
    chk({tag, " error_op"}, 32'(error_op), 32'(exp_err));
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, " valid dropped"}, 32'(resultado_valid), 0);
    chk({tag, " ready again"}, 32'(dato_ready), 1);
    chk({tag, " contador"}, 32'(contador_ops), 32'(exp_cnt));
  endtask

  initial begin
    reset           = 1'b1;
    dato_in         = '0;
    dato_valid      = 1'b0;
    cancelar        = 1'b0;
    resultado_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("por");

    run_cmd("suma",  8'd5,   8'd3,   8'h01, 8'd8,   1'b0);
    run_cmd("resta", 8'd3,   8'd5,   8'h02, 8'hFE, 1'b0);
    run_cmd("and",   8'hF0,  8'h3C,  8'h03, 8'h30, 1'b0);
    run_cmd("or",    8'hF0,  8'h3C,  8'h04, 8'hFC, 1'b0);
    run_cmd("carry", 8'hFF,  8'h01,  8'h01, 8'h00, 1'b0);
    run_cmd("badop", 8'd7,   8'd9,   8'hFF, 8'h00, 1'b1);
    chk("badop alu_op", 32'(alu_op), 7);
    run_cmd("okop",  8'd1,   8'd1,   8'h01, 8'd2,   1'b0);

    // Stall in ENTREGA with a word waiting on the input.
    resultado_ready = 1'b0;
    send(8'd10);
    send(8'd20);
    send(8'h01);
    tick();
    dato_in    = 8'h55;
    dato_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold valid", 32'(resultado_valid), 1);
      chk("hold resultado", 32'(resultado), 30);
      chk("hold dato_ready", 32'(dato_ready), 0);
      chk("hold contador", 32'(contador_ops), 32'(exp_cnt));
      chk("hold alu_a", 32'(alu_a), 10);
    end
    dato_valid      = 1'b0;
    resultado_ready = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    chk("hold release contador", 32'(contador_ops), 32'(exp_cnt));
    chk("hold release valid", 32'(resultado_valid), 0);
    chk("hold release dato_ready", 32'(dato_ready), 1);
    chk("hold resultado kept", 32'(resultado), 30);

    // Cancel in CARGA_OP with a word offered.
    send(8'd4);
    send(8'd6);
    dato_in    = 8'h03;
    dato_valid = 1'b1;
    cancelar   = 1'b1;
    tick();
    dato_valid = 1'b0;
    cancelar   = 1'b0;
    chk("cancel alu_op kept", 32'(alu_op), 1);
    chk("cancel alu_a kept", 32'(alu_a), 4);
    chk("cancel alu_b kept", 32'(alu_b), 6);
    chk("cancel dato_ready", 32'(dato_ready), 1);
    chk("cancel no valid", 32'(resultado_valid), 0);
    run_cmd("post cancel", 8'd2, 8'd2, 8'h01, 8'd4, 1'b0);

    // Reset while in ENTREGA with a result pending.
    resultado_ready = 1'b0;
    send(8'd9);
    send(8'd9);
    send(8'h01);
    tick();
    chk("pre-reset valid", 32'(resultado_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    check_reset_values("rst entrega");
    resultado_ready = 1'b1;
    tick();
    chk("rst entrega not counted", 32'(contador_ops), 0);

    run_cmd("pre rst op", 8'd1, 8'd2, 8'h01, 8'd3, 1'b0);

    // Reset while in CARGA_OP.
    send(8'd9);
    send(8'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    check_reset_values("rst carga_op");

    // Counter wrap.
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      send(8'd1);
      send(8'h01);
      tick();
      tick();
      if (i == 254) chk("cnt 255", 32'(contador_ops), 255);
    end
    chk("cnt wrap", 32'(contador_ops), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
